// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command master: frame opcodes, command
// encodings, FSM states and per-command frame/reply sizes.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CT_WR      = 2'd0,
    CT_RD      = 2'd1,
    CT_ALU_OP  = 2'd2,
    CT_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] FRAME_LEN_WR      = 3'd3;
  localparam logic [2:0] FRAME_LEN_RD      = 3'd2;
  localparam logic [2:0] FRAME_LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] FRAME_LEN_ALU_NOP = 3'd2;

  localparam logic [1:0] REPLY_CNT_WR  = 2'd0;
  localparam logic [1:0] REPLY_CNT_RD  = 2'd1;
  localparam logic [1:0] REPLY_CNT_ALU = 2'd2;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      CT_WR:     return FRAME_LEN_WR;
      CT_RD:     return FRAME_LEN_RD;
      CT_ALU_OP: return FRAME_LEN_ALU_OP;
      default:   return FRAME_LEN_ALU_NOP;
    endcase
  endfunction

  function automatic logic [1:0] reply_cnt(input cmd_type_e t);
    case (t)
      CT_WR:   return REPLY_CNT_WR;
      CT_RD:   return REPLY_CNT_RD;
      default: return REPLY_CNT_ALU;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_frame_mux.sv
// Combinational frame builder: selects the outgoing byte for a command at a
// given byte index and flags the final byte of the frame.
module uart_cmd_frame_mux
  import uart_cmd_pkg::*;
(
  input  logic [1:0] cmd_type,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [3:0] fun,
  input  logic [1:0] idx,
  output logic [7:0] byte_data,
  output logic       last_byte
);

  cmd_type_e t;

  always_comb begin
    t         = cmd_type_e'(cmd_type);
    byte_data = 8'h00;
    last_byte = ({1'b0, idx} == (frame_len(t) - 3'd1));
    case (t)
      CT_WR: begin
        case (idx)
          2'd0:    byte_data = CMD_WR;
          2'd1:    byte_data = {4'b0, addr};
          default: byte_data = wdata;
        endcase
      end
      CT_RD: begin
        byte_data = (idx == 2'd0) ? CMD_RD : {4'b0, addr};
      end
      CT_ALU_OP: begin
        case (idx)
          2'd0:    byte_data = CMD_ALU_OP;
          2'd1:    byte_data = op_a;
          2'd2:    byte_data = op_b;
          default: byte_data = {4'b0, fun};
        endcase
      end
      default: begin
        byte_data = (idx == 2'd0) ? CMD_ALU_NOP : {4'b0, fun};
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serialises one command into a byte frame,
// then gathers the reply bytes (with timeout) into a single response word.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [7:0]  cmd_op_a,
  input  logic [7:0]  cmd_op_b,
  input  logic [3:0]  cmd_alu_fun,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_CYCLES - 1'b1;

  state_e                state;
  cmd_type_e             c_type;
  logic [3:0]            c_addr;
  logic [7:0]            c_wdata;
  logic [7:0]            c_op_a;
  logic [7:0]            c_op_b;
  logic [3:0]            c_fun;
  logic [1:0]            byte_idx;
  logic                  tx_last;
  logic [1:0]            rx_cnt;
  logic [7:0]            rx_b0;
  logic [7:0]            rx_b1;
  logic [TIMEOUT_W-1:0]  to_cnt;

  logic [1:0] m_type;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_op_a;
  logic [7:0] m_op_b;
  logic [3:0] m_fun;
  logic [1:0] m_idx;
  logic [7:0] m_byte;
  logic       m_last;
  logic [7:0] nb0;
  logic [7:0] nb1;
  logic       rx_last;

  function automatic logic [15:0] assemble(input cmd_type_e t, input logic [7:0] b0,
                                           input logic [7:0] b1);
    case (t)
      CT_RD:                return {8'h00, b0};
      CT_ALU_OP, CT_ALU_NOP: return {b1, b0};
      default:              return 16'h0000;
    endcase
  endfunction

  // In IDLE the mux looks at the live request so byte 0 can be registered at
  // acceptance; afterwards it pre-computes the byte following the current one.
  always_comb begin
    if (state == ST_IDLE) begin
      m_type  = cmd_type;
      m_addr  = cmd_addr;
      m_wdata = cmd_wdata;
      m_op_a  = cmd_op_a;
      m_op_b  = cmd_op_b;
      m_fun   = cmd_alu_fun;
      m_idx   = 2'd0;
    end else begin
      m_type  = c_type;
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_op_a  = c_op_a;
      m_op_b  = c_op_b;
      m_fun   = c_fun;
      m_idx   = byte_idx + 2'd1;
    end
  end

  uart_cmd_frame_mux u_frame_mux (
    .cmd_type  (m_type),
    .addr      (m_addr),
    .wdata     (m_wdata),
    .op_a      (m_op_a),
    .op_b      (m_op_b),
    .fun       (m_fun),
    .idx       (m_idx),
    .byte_data (m_byte),
    .last_byte (m_last)
  );

  always_comb begin
    nb0     = (rx_valid && rx_cnt == 2'd0) ? rx_data : rx_b0;
    nb1     = (rx_valid && rx_cnt == 2'd1) ? rx_data : rx_b1;
    rx_last = ((rx_cnt + 2'd1) == reply_cnt(c_type));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      tx_last     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
      rsp_timeout <= 1'b0;
      byte_idx    <= 2'd0;
      rx_cnt      <= 2'd0;
      to_cnt      <= '0;
      rx_b0       <= 8'h00;
      rx_b1       <= 8'h00;
      c_type      <= CT_WR;
      c_addr      <= 4'h0;
      c_wdata     <= 8'h00;
      c_op_a      <= 8'h00;
      c_op_b      <= 8'h00;
      c_fun       <= 4'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            c_type      <= cmd_type_e'(cmd_type);
            c_addr      <= cmd_addr;
            c_wdata     <= cmd_wdata;
            c_op_a      <= cmd_op_a;
            c_op_b      <= cmd_op_b;
            c_fun       <= cmd_alu_fun;
            byte_idx    <= 2'd0;
            rx_cnt      <= 2'd0;
            rx_b0       <= 8'h00;
            rx_b1       <= 8'h00;
            to_cnt      <= '0;
            tx_data     <= m_byte;
            tx_last     <= m_last;
            tx_valid    <= 1'b1;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            rsp_timeout <= 1'b0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_valid && tx_ready) begin
            if (tx_last) begin
              tx_valid <= 1'b0;
              to_cnt   <= '0;
              if (reply_cnt(c_type) == 2'd0) begin
                rsp_valid   <= 1'b1;
                rsp_data    <= 16'h0000;
                rsp_timeout <= 1'b0;
                state       <= ST_DONE;
              end else begin
                state <= ST_WAIT_RSP;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx_data  <= m_byte;
              tx_last  <= m_last;
            end
          end
        end
        ST_WAIT_RSP: begin
          // A byte arriving on the timeout cycle takes priority over the abort.
          if (rx_valid) begin
            rx_b0  <= nb0;
            rx_b1  <= nb1;
            rx_cnt <= rx_cnt + 2'd1;
            to_cnt <= '0;
            if (rx_last) begin
              rsp_valid   <= 1'b1;
              rsp_data    <= assemble(c_type, nb0, nb1);
              rsp_timeout <= 1'b0;
              state       <= ST_DONE;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= assemble(c_type, nb0, nb1);
            rsp_timeout <= 1'b1;
            state       <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

- Host-side command initiator for the UART-controlled register-file/ALU system.
- Turns one command request into the byte frame the system controller expects, presents the bytes one at a time to a UART transmitter byte interface, then collects the reply bytes from a UART receiver and returns one response word.
- Used in the test harness and in host-side integration; its serial side faces the system's UART_RX_IN/UART_TX_O pins through standard UART TX/RX cores.

## Interface
Parameters:
- `TIMEOUT_W`, 16: width of the response-timeout counter.
- `TIMEOUT_CYCLES`, 16'd50000: number of CLK cycles without a reply byte before the transaction is aborted.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_type` in 2: 0 = reg write, 1 = reg read, 2 = ALU with operands, 3 = ALU without operands.
- `cmd_addr` in 4: register address.
- `cmd_wdata` in 8: write data.
- `cmd_op_a` in 8: ALU operand A.
- `cmd_op_b` in 8: ALU operand B.
- `cmd_alu_fun` in 4: ALU function code.
- `tx_data` out 8: byte to the UART TX core.
- `tx_valid` out 1: byte valid.
- `tx_ready` in 1: UART TX accepts the byte.
- `rx_data` in 8: byte from the UART RX core.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_data` out 16: response word.
- `rsp_timeout` out 1: qualifies `rsp_valid`; high = aborted on timeout.
- `busy` out 1: high whenever the block is not in IDLE.

## Operation
Frames (bytes listed in send order):
- Write: 0xAA, {4'b0, addr}, wdata. No reply expected.
- Read: 0xBB, {4'b0, addr}. 1 reply byte.
- ALU with operands: 0xCC, op_a, op_b, {4'b0, fun}. 2 reply bytes.
- ALU without operands: 0xDD, {4'b0, fun}. 2 reply bytes.

Command capture:
- All command fields are registered on acceptance.
- Inputs are ignored outside IDLE.

FSM states and transitions:
- IDLE -> SEND on `cmd_valid && cmd_ready`.
- SEND steps a byte index 0..N-1, advancing on each `tx_valid && tx_ready`.
- After the last byte is handshaked: SEND -> WAIT_RSP if replies are expected, otherwise SEND -> DONE.
- WAIT_RSP -> DONE once all expected bytes have arrived, or on timeout.
- DONE -> IDLE unconditionally. `rsp_valid` is high for exactly that one cycle.

Response assembly:
- Read: `rsp_data` = {8'h00, byte0}.
- ALU: `rsp_data` = {byte1, byte0}, low byte first.
- Write: `rsp_data` = 16'h0000.

Byte reception rules:
- `rx_valid` outside WAIT_RSP is discarded.
- Extra bytes after completion are discarded.

Timeout:
- The counter clears on entry to WAIT_RSP and on each `rx_valid`.
- When it reaches `TIMEOUT_CYCLES`, go to DONE with `rsp_timeout`=1.
- `rsp_data` then holds any bytes already received; missing bytes are 0.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1.
  - `tx_valid`=0, `tx_data`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0.
  - `busy`=0.
  - All counters 0.
- Reset asserted mid-transaction: return to IDLE on the next edge. No `rsp_valid` is produced and the partial frame is abandoned.
- `tx_valid` rises the cycle after command acceptance.
- `tx_data`/`tx_valid` are registered and stay stable while `tx_valid && !tx_ready`.
- The next byte is presented the cycle after a handshake, so back-to-back bytes are possible when `tx_ready` is held high.
- `tx_valid` deasserts the cycle after the last handshake.
- `rx_valid` coinciding with the last tx handshake is ignored, because the state is not yet WAIT_RSP.
- `rx_valid` in the same cycle the timeout count is reached: the byte wins, and the counter clears.
- Latency from last expected `rx_valid` to `rsp_valid`: 1 cycle (registered DONE).
- For a write command, `rsp_valid` comes 1 cycle after the last tx handshake.
- `cmd_ready` returns high the cycle after DONE.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - Frame opcodes `CMD_WR`=8'hAA, `CMD_RD`=8'hBB, `CMD_ALU_OP`=8'hCC, `CMD_ALU_NOP`=8'hDD.
  - The `cmd_type` encodings.
  - The FSM state enum.
  - Per-type frame length and reply count constants.
- One sub-module, `uart_cmd_frame_mux`: purely combinational. It maps {captured command, byte index} to the outgoing byte and last-byte flag.
- The FSM, counters and reply assembly live in the top.

## Test plan
1. Write, addr=4'h5, wdata=8'h3C, `tx_ready` held high -> bytes AA,05,3C on 3 consecutive cycles; `rsp_valid` 1 cycle later with `rsp_data`=0000 and `rsp_timeout`=0.
2. Read, addr=4'h2, reply byte 8'h81 -> tx AA-free frame BB,02; `rsp_data`=0081, 1 cycle after `rx_valid`.
3. ALU with operands, A=8'h10, B=8'h20, fun=4'h0, replies 30,00; `tx_ready` toggling 1/0 -> frame CC,10,20,00 with data held stable while `tx_ready`=0; `rsp_data`=0030.
4. ALU without operands, fun=4'h2, only one reply byte 8'hFF, then silence for `TIMEOUT_CYCLES` -> `rsp_valid` with `rsp_timeout`=1 and `rsp_data`=00FF; `cmd_ready`=1 on the next cycle.
5. `RST` asserted after the 2nd tx byte of an ALU-with-operands frame -> IDLE next cycle, `tx_valid`=0, no `rsp_valid`; a subsequent read completes normally.
6. Stray `rx_valid` while in IDLE or SEND, and `cmd_valid` while busy -> both ignored; the next response is unaffected.
